if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
//  Holds the PC and issues word fetches to instruction memory over a req/ready port.
//  Latches each returned instruction with its PC into IF/ID, which drives decode and imm_gen.
//  Absorbs hazard-unit stalls with a 1-entry skid buffer.
//  Handles branch/jump redirects from EX by tagging fetches with an epoch and dropping stale ones.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  instruction presented on ifid_instr when ifid_valid=0 (ADDI x0,x0,0)
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch byte address (bits[1:0] always 0)
//  imem_ready     in   1   memory accepts request this cycle
//  imem_rvalid    in   1   response valid; exactly 1 cycle after an accepted request
//  imem_rdata     in   32  fetched instruction word
//  stall          in   1   hazard unit: hold IF/ID and PC
//  redirect_valid in   1   EX: taken branch/JAL/JALR; overrides stall
//  redirect_pc    in   32  new fetch PC (bits[1:0] forced to 0)
//  ifid_valid     out  1   IF/ID holds a real instruction
//  ifid_pc        out  32  PC of ifid_instr
//  ifid_instr     out  32  instruction to decode/imm_gen; NOP_INSTR when ifid_valid=0
// BEHAVIOUR
//  Reset: pc=RESET_PC, epoch=0, inflight=0, skid_valid=0, ifid_valid=0, ifid_pc=0,
//   ifid_instr=NOP_INSTR, imem_req=0. imem_req may rise in the first cycle after rst falls.
//  Issue:
//   - imem_req = !rst && !stall && !redirect_valid; imem_addr = pc.
//   - Accept = imem_req && imem_ready. On accept: pc <= pc+4 (wraps mod 2^32),
//     inflight <= 1, inflight_epoch <= epoch.
//   - At most one fetch is outstanding, so the skid buffer never overflows.
//  Response (imem_rvalid=1):
//   - Drop it if inflight_epoch != epoch, or if redirect_valid is high in the same cycle.
//   - Otherwise, if !stall: IF/ID <= {1, fetch_pc, rdata}.
//   - Otherwise, if stall: skid <= {pc, rdata}, skid_valid <= 1.
//  IF/ID update when !stall and no redirect, in priority order:
//   1. skid_valid: load IF/ID from skid, clear skid.
//   2. Live response: load IF/ID from the response.
//   3. Neither: ifid_valid <= 0 (bubble), ifid_instr <= NOP_INSTR.
//  Stall: IF/ID, pc and skid hold. No new request. A response already in flight lands in skid.
//  Redirect (highest priority, including over stall):
//   - pc <= {redirect_pc[31:2],2'b00}; epoch <= ~epoch; skid_valid <= 0.
//   - ifid_valid <= 0, ifid_instr <= NOP_INSTR.
//   - Fetch from the new pc starts the next cycle.
//  Latency:
//   - Request accepted in cycle N; instruction visible on ifid_* in cycle N+2.
//   - Steady throughput: 1 instruction/cycle with imem_ready=1.
//   - Redirect penalty: 2 bubbles.
//  imem_ready=0: pc holds, request stays asserted with a stable address, IF/ID bubbles.
//  rst mid-operation: all state returns to reset values on the next edge. In-flight response is ignored.
// STRUCTURE
//  rv_pkg (shared): NOP_INSTR, opcode localparams already used by imm_gen/decode, XLEN=32.
//  Sub-module fetch_skid_buf: 1-entry {pc,instr} buffer with load/drain/clear.
//  PC, epoch and IF/ID registers live in if_stage.
// TESTING
//  T1 reset: hold rst 3 cycles -> ifid_valid=0, ifid_instr=0x00000013, first imem_addr=RESET_PC.
//  T2 streaming: ready=1, mem returns addr-tagged words -> ifid_pc 0,4,8,12 on consecutive cycles
//     from cycle 2; no gaps.
//  T3 stall with fetch in flight: stall 3 cycles right after accept of 0x8 -> IF/ID holds 0x4;
//     on release 0x8 emerges from skid, then 0xC with no bubble and no duplicate.
//  T4 redirect: redirect_pc=0x100 while fetch of 0x10 is in flight -> 0x10 never appears;
//     2 bubbles, then ifid_pc=0x100, 0x104.
//  T5 redirect during stall with skid full: redirect_pc=0x203 -> skid cleared, ifid_valid=0,
//     next fetch address 0x200.
//  T6 imem_ready low 4 cycles at pc=0x20 -> imem_addr stays 0x20; bubbles; resumes at 0x20, 0x24.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared RV32I fetch definitions: word width, canonical NOP and the fetch-entry record
// carried through the skid buffer and IF/ID.
package if_stage_pkg;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low two bits are discarded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response port: one request per accept, response one cycle later.
interface if_stage_if;
  import if_stage_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/if_stage_fetch_skid_buf.sv
// One-entry {pc,instr} holding register that catches a response landing while decode is stalled.
module fetch_skid_buf
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         drain,
  input  fetch_entry_t load_data,
  output logic         valid,
  output fetch_entry_t data
);

  logic         valid_r;
  fetch_entry_t data_r;

  // Clear wins over load; a load in the same cycle as a drain refills the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage and IF/ID register: PC, epoch-tagged single outstanding fetch,
// stall absorption through a one-entry skid buffer, and EX redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  logic [31:0]  pc_r;
  logic [31:0]  fetch_pc_r;
  logic         epoch_r;
  logic         inflight_r;
  logic         inflight_epoch_r;
  logic         ifid_valid_r;
  logic [31:0]  ifid_pc_r;
  logic [31:0]  ifid_instr_r;

  logic         req_s;
  logic         accept_s;
  logic         resp_live_s;
  logic         skid_load_s;
  logic         skid_drain_s;
  logic         skid_valid_s;
  fetch_entry_t skid_data_s;
  fetch_entry_t resp_entry_s;

  assign req_s    = !rst && !stall && !redirect_valid;
  assign accept_s = req_s && imem.ready;

  // A response from an older epoch, or one colliding with a redirect, is discarded.
  assign resp_live_s  = imem.rvalid && inflight_r && (inflight_epoch_r == epoch_r)
                        && !redirect_valid && !rst;
  assign resp_entry_s = '{pc: fetch_pc_r, instr: imem.rdata};
  assign skid_drain_s = !stall && !redirect_valid && skid_valid_s;
  assign skid_load_s  = resp_live_s && (stall || skid_valid_s);

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .load      (skid_load_s),
    .drain     (skid_drain_s),
    .load_data (resp_entry_s),
    .valid     (skid_valid_s),
    .data      (skid_data_s)
  );

  // PC, epoch and outstanding-fetch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r             <= RESET_PC;
      epoch_r          <= 1'b0;
      inflight_r       <= 1'b0;
      inflight_epoch_r <= 1'b0;
      fetch_pc_r       <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_r       <= align_pc(redirect_pc);
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= accept_s;
      if (accept_s) begin
        pc_r             <= pc_r + 32'd4;
        fetch_pc_r       <= pc_r;
        inflight_epoch_r <= epoch_r;
      end
    end
  end

  // IF/ID register: skid entry is older than a live response, so it goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_r <= 1'b0;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_instr_r <= NOP_INSTR;
    end else if (redirect_valid) begin
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= NOP_INSTR;
    end else if (stall) begin
      ifid_valid_r <= ifid_valid_r;
    end else if (skid_valid_s) begin
      ifid_valid_r <= 1'b1;
      ifid_pc_r    <= skid_data_s.pc;
      ifid_instr_r <= skid_data_s.instr;
    end else if (resp_live_s) begin
      ifid_valid_r <= 1'b1;
      ifid_pc_r    <= fetch_pc_r;
      ifid_instr_r <= imem.rdata;
    end else begin
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= NOP_INSTR;
    end
  end

  assign imem.req   = req_s;
  assign imem.addr  = pc_r;
  assign ifid_valid = ifid_valid_r;
  assign ifid_pc    = ifid_pc_r;
  assign ifid_instr = ifid_instr_r;

endmodule
